ysyx_lsu_sram_slave: RTL
========================

// Module: ysyx_lsu_sram_slave
// PURPOSE
//  Bus responder for the LSU load/store channels; backs an on-chip SRAM window (default 0x0f000000, 8 KiB).
//  Serves one request at a time and answers reads with a full aligned word; the LSU does byte extraction.
//  Read and write channels share one array; a round-robin arbiter serialises them.
//  Sits behind the LSU bus mux in place of the external sram model.
// PARAMETERS
//  XLEN      32            data/address width
//  DEPTH_LEN 11            log2(words); array = 2**DEPTH_LEN x 32b
//  BASE_ADDR 32'h0f000000  window base; window size = 4*2**DEPTH_LEN bytes
//  RD_LAT    1             extra wait cycles before rvalid (0..15)
//  WR_LAT    1             extra wait cycles before wready (0..15)
// PORTS
//  clock      in   1     system clock
//  reset_n    in   1     asynchronous, active-low reset
//  araddr     in   XLEN  load byte address
//  arvalid    in   1     load request; held until rvalid is seen
//  rstrb      in   8     load byte mask (1/3/f); used only for the misaligned check
//  rdata      out  XLEN  word at araddr[XLEN-1:2]
//  rvalid     out  1     one-cycle read-response pulse
//  awaddr     in   XLEN  store byte address
//  awvalid    in   1     store address valid
//  wdata      in   XLEN  store data, lane 0 aligned (unshifted)
//  wstrb      in   8     store byte mask, lane 0 aligned; bits [7:4] ignored
//  wvalid     in   1     store data valid; store accepted only when awvalid&&wvalid
//  wready     out  1     one-cycle write-ack pulse
//  err        out  1     one-cycle pulse with rvalid/wready on out-of-window or lane-overflow access
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, cnt=0, rvalid=0, wready=0, err=0, rdata=0, rr_last=READ.
//   Array contents are not reset.
//  Reset mid-transaction: the transaction is dropped with no response and no array write.
//  FSM IDLE / RD_WAIT / RD_RESP / WR_WAIT / WR_RESP.
//  IDLE: rd_req=arvalid, wr_req=awvalid&&wvalid.
//   - Only one request pending: take it.
//   - Both pending: take the opposite of rr_last, then update rr_last.
//   - Taking a request latches addr, mask and data; cnt<=RD_LAT (read) or WR_LAT (write).
//  RD_WAIT: cnt!=0 -> cnt--. cnt==0 -> read array, ->RD_RESP.
//  RD_RESP: rvalid=1 for exactly one cycle with rdata valid, then ->IDLE. rdata holds until the next read.
//  WR_WAIT: cnt!=0 -> cnt--. cnt==0 -> write array, ->WR_RESP.
//  WR_RESP: wready=1 for exactly one cycle, then ->IDLE.
//  Latency, request sampled in IDLE at edge t: rvalid/wready high in cycle t+2+LAT.
//   With RD_LAT=0, rvalid is high in cycle t+2.
//  Request lowered before its response: the latched transaction still completes and still pulses.
//  Initiator holds the request through the pulse and drops it the cycle after.
//   IDLE re-samples only after the pulse cycle, so one request never produces two responses.
//  Store lane rule:
//   - sh = waddr[1:0].
//   - mask8 = wstrb[3:0] << sh; bytes = mask8[3:0]; data = wdata << 8*sh.
//   - mask8[7:4]!=0 (crosses the word): the in-word bytes are written and err pulses with wready.
//  Load misalignment: (rstrb[3:0] << araddr[1:0]) overflows 4 bits -> word still returned, err pulses with rvalid.
//  Out-of-window (addr-BASE_ADDR >= window size, unsigned):
//   - read: rdata=0, err=1.
//   - write: no array write, err=1.
//   - Latency is unchanged.
//  Index = (addr-BASE_ADDR)[DEPTH_LEN+1:2]. Latency counter is 4 bits.
// STRUCTURE
//  Shared (ysyx.svh): YSYX_SRAM_BASE and YSYX_SRAM_LEN defines; the slave-state enum typedef
//   (ysyx_slv_state_t), reusable by the clint/uart responders.
//  Sub-module ysyx_sram_bank: synchronous 1R/1W byte-enable array.
//   - Ports: clock, ren, raddr, rdata, wen, waddr, wbe[3:0], wdata.
//   - rdata is registered and updates only on ren.
//  Top holds the FSM, arbiter, lane shifting and range check.
// TESTING
//  1. reset_n low mid-RD_WAIT -> rvalid/wready/err=0 immediately; no response after release; next read served normally.
//  2. sw 0xdeadbeef @0x0f000010, then lw @0x0f000010 (RD_LAT=WR_LAT=1)
//     -> wready in cycle t+3; rdata=0xdeadbeef with rvalid in cycle t+3 of the read; err=0.
//  3. sb wdata=0x000000aa, wstrb=0x1 @0x0f000013 over 0x11223344 -> read 0xaa223344.
//     sh @0x0f000013 -> byte 3 written, err=1.
//  4. arvalid and awvalid&&wvalid raised in the same cycle after reset (rr_last=READ)
//     -> write served first, then read; exactly one wready and one rvalid pulse.
//  5. lw @0x0f002000 (just past the window) -> rdata=0, err=1, rvalid single pulse.
//     Request held 3 extra cycles -> no second rvalid.
//  6. RD_LAT=0 and RD_LAT=15 builds: rvalid arrives in cycles t+2 and t+17; back-to-back lw every response leaves exactly one idle cycle between transactions.

Source files
------------

// File: rtl/ysyx_lsu_sram_slave_pkg.sv
// rtl/ysyx_lsu_sram_slave_pkg.sv - shared window constants, slave-state encoding and lane helper
package ysyx_lsu_sram_slave_pkg;

    localparam logic [31:0] YSYX_SRAM_BASE = 32'h0f00_0000;
    localparam int unsigned YSYX_SRAM_LEN  = 32'h0000_2000;

    // Slave-state encoding, shared with the other single-request responders.
    typedef logic [2:0] ysyx_slv_state_t;

    localparam ysyx_slv_state_t SLV_IDLE    = 3'd0;
    localparam ysyx_slv_state_t SLV_RD_WAIT = 3'd1;
    localparam ysyx_slv_state_t SLV_RD_RESP = 3'd2;
    localparam ysyx_slv_state_t SLV_WR_WAIT = 3'd3;
    localparam ysyx_slv_state_t SLV_WR_RESP = 3'd4;

    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    function automatic logic [7:0] lane_mask8(input logic [1:0] sh, input logic [3:0] mask);
        return {4'b0000, mask} << sh;
    endfunction

endpackage

// File: rtl/ysyx_lsu_sram_slave_bank.sv
// rtl/ysyx_lsu_sram_slave_bank.sv - synchronous 1R/1W byte-enable SRAM array
module ysyx_sram_bank #(
    parameter int XLEN      = 32,
    parameter int DEPTH_LEN = 11
) (
    input  logic                 clock,
    input  logic                 ren,
    input  logic [DEPTH_LEN-1:0] raddr,
    output logic [XLEN-1:0]      rdata,
    input  logic                 wen,
    input  logic [DEPTH_LEN-1:0] waddr,
    input  logic [3:0]           wbe,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] mem [2**DEPTH_LEN];

    always_ff @(posedge clock) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ysyx_lsu_sram_slave.sv
// rtl/ysyx_lsu_sram_slave.sv - LSU SRAM window responder: arbiter, latency FSM, lane shift, range check
module ysyx_lsu_sram_slave
    import ysyx_lsu_sram_slave_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH_LEN = $clog2(YSYX_SRAM_LEN / 4),
    parameter logic [XLEN-1:0] BASE_ADDR = YSYX_SRAM_BASE,
    parameter int              RD_LAT    = 1,
    parameter int              WR_LAT    = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] araddr,
    input  logic            arvalid,
    input  logic [7:0]      rstrb,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid,
    input  logic [XLEN-1:0] awaddr,
    input  logic            awvalid,
    input  logic [XLEN-1:0] wdata,
    input  logic [7:0]      wstrb,
    input  logic            wvalid,
    output logic            wready,
    output logic            err
);

    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(4 * (2 ** DEPTH_LEN));

    ysyx_slv_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rr_last_q, rr_last_d;
    logic            rvalid_q, rvalid_d;
    logic            wready_q, wready_d;
    logic            err_q, err_d;

    logic [XLEN-1:0]      off;
    logic                 in_range;
    logic [1:0]           sh;
    logic [7:0]           mask8;
    logic                 lane_ovf;
    logic [DEPTH_LEN-1:0] idx;
    logic [XLEN-1:0]      bank_rdata;
    logic [XLEN-1:0]      bank_wdata;
    logic                 bank_ren, bank_wen;
    logic                 rd_req, wr_req, take_rd, take_wr;
    logic                 unused_ok;

    assign off        = addr_q - BASE_ADDR;
    assign in_range   = off < WIN_BYTES;
    assign idx        = off[DEPTH_LEN+1:2];
    assign sh         = addr_q[1:0];
    assign mask8      = lane_mask8(sh, mask_q);
    assign lane_ovf   = |mask8[7:4];
    assign bank_wdata = wdata_q << {sh, 3'b000};
    assign unused_ok  = ^{rstrb[7:4], wstrb[7:4]};

    // A pulse still on the outputs means the initiator has not dropped that request yet.
    assign rd_req  = arvalid;
    assign wr_req  = awvalid && wvalid;
    assign take_wr = !(rvalid_q || wready_q) && wr_req && (!rd_req || rr_last_q == RR_READ);
    assign take_rd = !(rvalid_q || wready_q) && rd_req && !take_wr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rdata_d   = rdata_q;
        rr_last_d = rr_last_q;
        rvalid_d  = 1'b0;
        wready_d  = 1'b0;
        err_d     = 1'b0;
        bank_ren  = 1'b0;
        bank_wen  = 1'b0;
        case (state_q)
            SLV_IDLE: begin
                if (take_wr) begin
                    state_d   = SLV_WR_WAIT;
                    addr_d    = awaddr;
                    wdata_d   = wdata;
                    mask_d    = wstrb[3:0];
                    cnt_d     = 4'(WR_LAT);
                    rr_last_d = RR_WRITE;
                end else if (take_rd) begin
                    state_d   = SLV_RD_WAIT;
                    addr_d    = araddr;
                    mask_d    = rstrb[3:0];
                    cnt_d     = 4'(RD_LAT);
                    rr_last_d = RR_READ;
                end
            end
            SLV_RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    bank_ren = in_range;
                    state_d  = SLV_RD_RESP;
                end
            end
            SLV_RD_RESP: begin
                rvalid_d = 1'b1;
                err_d    = !in_range || lane_ovf;
                rdata_d  = in_range ? bank_rdata : '0;
                state_d  = SLV_IDLE;
            end
            SLV_WR_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    bank_wen = in_range;
                    state_d  = SLV_WR_RESP;
                end
            end
            SLV_WR_RESP: begin
                wready_d = 1'b1;
                err_d    = !in_range || lane_ovf;
                state_d  = SLV_IDLE;
            end
            default: state_d = SLV_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SLV_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= 4'd0;
            rdata_q   <= '0;
            rr_last_q <= RR_READ;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
            rr_last_q <= rr_last_d;
            rvalid_q  <= rvalid_d;
            wready_q  <= wready_d;
            err_q     <= err_d;
        end
    end

    ysyx_sram_bank #(
        .XLEN      (XLEN),
        .DEPTH_LEN (DEPTH_LEN)
    ) u_bank (
        .clock (clock),
        .ren   (bank_ren),
        .raddr (idx),
        .rdata (bank_rdata),
        .wen   (bank_wen),
        .waddr (idx),
        .wbe   (mask8[3:0]),
        .wdata (bank_wdata)
    );

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign wready = wready_q;
    assign err    = err_q;

endmodule
